// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response and decode valid/ready signals of the fetch stage.
// The fetch sequencer uses the master view; the memory/decode side uses the slave view.
interface fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata,
        output inst_valid,
        output inst,
        output inst_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata,
        input  inst_valid,
        input  inst,
        input  inst_pc,
        output inst_ready
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: one memory request per fetch, a one-entry decode buffer,
// and branch redirects that squash a response fetched on the wrong path.
module fetch_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  pc,
    output logic         pc_enable,
    output logic         pc_mux,
    output logic [31:0]  target,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_target,
    fetch_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t      state_r;
    logic        kill_r;
    logic        imem_req_r;
    logic [31:0] req_addr_r;
    logic        inst_valid_r;
    logic [31:0] inst_r;
    logic [31:0] inst_pc_r;
    logic        accept_s;

    assign bus.imem_req   = imem_req_r;
    assign bus.imem_addr  = req_addr_r;
    assign bus.inst_valid = inst_valid_r;
    assign bus.inst       = inst_r;
    assign bus.inst_pc    = inst_pc_r;

    // PC update strobe: a redirect always wins over the sequential step of an accepted fetch
    always_comb begin
        accept_s  = 1'b0;
        pc_enable = 1'b0;
        pc_mux    = 1'b0;
        target    = redirect_target;
        if (rst) begin
            pc_enable = 1'b0;
            pc_mux    = 1'b0;
        end else if (redirect_valid) begin
            pc_enable = 1'b1;
            pc_mux    = 1'b1;
        end else if ((state_r == ST_REQ) && bus.imem_rvalid && !kill_r) begin
            pc_enable = 1'b1;
            accept_s  = 1'b1;
        end else begin
            pc_enable = 1'b0;
        end
    end

    // Fetch sequencer with registered request and instruction-buffer outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            kill_r       <= 1'b0;
            imem_req_r   <= 1'b0;
            req_addr_r   <= 32'd0;
            inst_valid_r <= 1'b0;
            inst_r       <= 32'd0;
            inst_pc_r    <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    req_addr_r   <= redirect_valid ? redirect_target : pc;
                    imem_req_r   <= 1'b1;
                    inst_valid_r <= 1'b0;
                    state_r      <= ST_REQ;
                end
                ST_REQ: begin
                    if (bus.imem_rvalid) begin
                        imem_req_r <= 1'b0;
                        kill_r     <= 1'b0;
                        if (accept_s) begin
                            inst_r       <= bus.imem_rdata;
                            inst_pc_r    <= req_addr_r;
                            inst_valid_r <= 1'b1;
                            state_r      <= ST_HOLD;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else if (redirect_valid) begin
                        // the address stays put until the wrong-path response drains
                        kill_r <= 1'b1;
                    end else begin
                        kill_r <= kill_r;
                    end
                end
                ST_HOLD: begin
                    if (redirect_valid || bus.inst_ready) begin
                        inst_valid_r <= 1'b0;
                        state_r      <= ST_IDLE;
                    end else begin
                        inst_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    kill_r       <= 1'b0;
                    imem_req_r   <= 1'b0;
                    inst_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a transaction-level fetch model drives the PC register and
// instruction memory and is compared against the DUT on every falling edge.
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h1c00_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        pc_enable;
    logic        pc_mux;
    logic [31:0] target;
    logic        redirect_valid;
    logic [31:0] redirect_target;

    fetch_ctrl_if bif ();

    fetch_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .pc              (pc_in),
        .pc_enable       (pc_enable),
        .pc_mux          (pc_mux),
        .target          (target),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .bus             (bif.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int lat    = 0;

    // model: an open fetch (address, wrong-path flag, cycles waited), a one-entry buffer, the PC
    bit          m_live  = 1'b0;
    bit          m_open  = 1'b0;
    bit          m_wrong = 1'b0;
    bit          m_full  = 1'b0;
    int          m_wait  = 0;
    logic [31:0] m_addr  = 32'd0;
    logic [31:0] m_inst  = 32'd0;
    logic [31:0] m_ipc   = 32'd0;
    logic [31:0] m_pc    = RESET_PC;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model update on each edge, then PC register and memory responder follow the model
    always @(posedge clk) begin
        bit step;
        if (rst) begin
            m_live = 1'b1; m_open = 1'b0; m_wrong = 1'b0; m_full = 1'b0; m_wait = 0;
            m_addr = 32'd0; m_inst = 32'd0; m_ipc = 32'd0; m_pc = RESET_PC;
        end else if (m_live) begin
            step = redirect_valid || (m_open && bif.imem_rvalid && !m_wrong);
            if (!m_open && !m_full) begin
                m_open = 1'b1;
                m_addr = redirect_valid ? redirect_target : pc_in;
                m_wait = 0;
            end else if (m_open) begin
                if (bif.imem_rvalid) begin
                    m_open = 1'b0;
                    if (!redirect_valid && !m_wrong) begin
                        m_full = 1'b1;
                        m_inst = bif.imem_rdata;
                        m_ipc  = m_addr;
                    end
                    m_wrong = 1'b0;
                end else begin
                    m_wait++;
                    if (redirect_valid) m_wrong = 1'b1;
                end
            end else if (redirect_valid || bif.inst_ready) begin
                m_full = 1'b0;
            end
            if (step) m_pc = redirect_valid ? redirect_target : m_pc + 32'd4;
        end
        #1;
        pc_in           = m_pc;
        bif.imem_rvalid = m_open && (m_wait >= lat);
        bif.imem_rdata  = word_at(m_addr);
    end

    // Compare DUT outputs with the model away from the active edge
    always @(negedge clk) begin
        bit exp_en;
        if (m_live) begin
            exp_en = !rst && (redirect_valid || (m_open && bif.imem_rvalid && !m_wrong));
            chk("pc_enable",  32'(pc_enable),      32'(exp_en));
            chk("pc_mux",     32'(pc_mux),         32'(!rst && redirect_valid));
            chk("target",     target,              redirect_target);
            chk("imem_req",   32'(bif.imem_req),   32'(m_open));
            if (m_open) chk("imem_addr", bif.imem_addr, m_addr);
            chk("inst_valid", 32'(bif.inst_valid), 32'(m_full));
            chk("inst",       bif.inst,            m_inst);
            chk("inst_pc",    bif.inst_pc,         m_ipc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_fetch(input logic [31:0] a, input string nm);
        bit found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (m_open && (m_addr == a)) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk(nm, 32'(found), 32'd1);
        chk({nm, "_addr"}, bif.imem_addr, a);
    endtask

    task automatic wait_until_rvalid();
        bit found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bif.imem_rvalid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("wait_rvalid", 32'(found), 32'd1);
    endtask

    task automatic wait_until_full();
        bit found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (m_full) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("wait_hold", 32'(found), 32'd1);
    endtask

    task automatic check_reset_values(input string nm);
        chk({nm, "_imem_req"},   32'(bif.imem_req),   32'd0);
        chk({nm, "_imem_addr"},  bif.imem_addr,       32'd0);
        chk({nm, "_inst_valid"}, 32'(bif.inst_valid), 32'd0);
        chk({nm, "_inst"},       bif.inst,            32'd0);
        chk({nm, "_inst_pc"},    bif.inst_pc,         32'd0);
        chk({nm, "_pc_enable"},  32'(pc_enable),      32'd0);
    endtask

    initial begin
        rst = 1'b1; pc_in = RESET_PC; redirect_valid = 1'b0; redirect_target = 32'd0;
        bif.imem_rvalid = 1'b0; bif.imem_rdata = 32'd0; bif.inst_ready = 1'b1;
        tick(); tick();
        check_reset_values("reset");

        // first fetch with a same-cycle response
        rst = 1'b0;
        tick();
        chk("first_req",    32'(bif.imem_req), 32'd1);
        chk("first_addr",   bif.imem_addr,     32'h1c00_0000);
        chk("first_pc_en",  32'(pc_enable),    32'd1);
        chk("first_pc_mux", 32'(pc_mux),       32'd0);
        bif.inst_ready = 1'b0;
        tick();
        chk("first_valid", 32'(bif.inst_valid), 32'd1);
        chk("first_ipc",   bif.inst_pc,         32'h1c00_0000);
        chk("first_inst",  bif.inst,            32'hC2AD_BEEF);

        // decode backpressure
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_req",   32'(bif.imem_req), 32'd0);
            chk("bp_pc_en", 32'(pc_enable),    32'd0);
            chk("bp_ipc",   bif.inst_pc,       32'h1c00_0000);
        end
        bif.inst_ready = 1'b1;
        tick();

        // redirect during an outstanding request
        lat = 3;
        tick();
        chk("seq_addr", bif.imem_addr, 32'h1c00_0004);
        redirect_valid = 1'b1; redirect_target = 32'h1c00_0100;
        #1;
        chk("rd_req_pc_en",  32'(pc_enable), 32'd1);
        chk("rd_req_pc_mux", 32'(pc_mux),    32'd1);
        chk("rd_req_target", target,         32'h1c00_0100);
        tick();
        redirect_valid = 1'b0;
        wait_fetch(32'h1c00_0100, "after_kill");

        // redirect coinciding with the response
        lat = 2;
        wait_until_rvalid();
        redirect_valid = 1'b1; redirect_target = 32'h1c00_0200;
        #1;
        chk("rd_rv_pc_mux", 32'(pc_mux), 32'd1);
        tick();
        redirect_valid = 1'b0;
        chk("rd_rv_dropped", 32'(bif.inst_valid), 32'd0);
        lat = 0;
        wait_fetch(32'h1c00_0200, "after_rv_redirect");

        // redirect in HOLD while decode is ready
        wait_until_full();
        bif.inst_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h1c00_0300;
        tick();
        redirect_valid = 1'b0;
        chk("rd_hold_flush", 32'(bif.inst_valid), 32'd0);
        lat = 6;
        wait_fetch(32'h1c00_0300, "after_hold_redirect");

        // repeated redirects while the response is still owed
        redirect_valid = 1'b1; redirect_target = 32'h1c00_0400;
        tick();
        redirect_target = 32'h1c00_0500;
        tick();
        redirect_valid = 1'b0;
        chk("kill_addr_held", bif.imem_addr, 32'h1c00_0300);
        wait_fetch(32'h1c00_0500, "after_double_redirect");

        // reset while a killed request is outstanding
        redirect_valid = 1'b1; redirect_target = 32'h1c00_0600;
        tick();
        redirect_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check_reset_values("midreset");
        rst = 1'b0; lat = 0;
        wait_fetch(RESET_PC, "restart");

        // sustained stream with mixed latency and decode stalls
        for (int i = 0; i < 30; i++) begin
            bif.inst_ready = (i % 3) != 0;
            lat = i % 3;
            tick();
        end
        bif.inst_ready = 1'b1;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
